// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: opcode/aluop constants, mul/div wait FSM encoding and decode helper.
package pipeline_stall_ctrl_pkg;
    localparam logic [4:0] OP_RTYPE  = 5'b00000;
    localparam logic [4:0] OP_ADDI   = 5'b00101;
    localparam logic [4:0] OP_SW     = 5'b00111;
    localparam logic [4:0] OP_LW     = 5'b01000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;
    typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} md_state_t;
    function automatic logic is_rtype_alu(input logic [31:0] insn, input logic [4:0] aluop);
        return insn[31:27] == OP_RTYPE && insn[6:2] == aluop;
    endfunction
endpackage

// File: rtl/pipeline_stall_ctrl_md_wait_fsm.sv
// md_wait_fsm: multdiv start pulses, wait state with bounded counter, release/timeout detection.
module md_wait_fsm
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_is_mul,
    input  logic i_is_div,
    input  logic i_branch_taken,
    input  logic i_md_ready,
    output logic o_md_ctrl_mult,
    output logic o_md_ctrl_div,
    output logic o_md_busy,
    output logic o_release,
    output logic o_md_timeout
);
    md_state_t        r_state;
    logic [CNT_W-1:0] r_md_cnt;
    logic             w_idle;
    logic             w_cnt_hit;
    assign w_idle    = !i_reset && r_state == IDLE;
    assign w_cnt_hit = r_md_cnt == CNT_W'(MD_TIMEOUT - 1);
    // A taken branch squashes the mul/div sitting in DX, so it must not start.
    assign o_md_ctrl_mult = w_idle && !i_branch_taken && i_is_mul;
    assign o_md_ctrl_div  = w_idle && !i_branch_taken && i_is_div;
    assign o_md_busy      = !i_reset && r_state == MD_WAIT;
    assign o_release      = o_md_busy && (i_md_ready || w_cnt_hit);
    assign o_md_timeout   = o_md_busy && w_cnt_hit && !i_md_ready;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_md_cnt <= '0;
        end else begin
            r_state  <= (r_state == IDLE) ? ((o_md_ctrl_mult || o_md_ctrl_div) ? MD_WAIT : IDLE)
                                          : (o_release ? IDLE : MD_WAIT);
            r_md_cnt <= (r_state == IDLE || o_release) ? '0 : r_md_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: priority mux of pipeline enables/flushes/bubbles over branch, mul/div and RAW hazards.
// Optional perf counters enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_insn,
    input  logic        data_hazard,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        fd_flush,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        md_busy,
    output logic        md_timeout
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] perf_hazard_cyc,
    output logic [31:0] perf_md_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);
    logic w_is_mul;
    logic w_is_div;
    logic w_release;
    logic w_start;
    logic w_unused;
    assign w_is_mul = is_rtype_alu(dx_insn, ALUOP_MUL);
    assign w_is_div = is_rtype_alu(dx_insn, ALUOP_DIV);
    assign w_unused = ^{dx_insn[26:7], dx_insn[1:0]};
    assign w_start  = md_ctrl_mult || md_ctrl_div;

    md_wait_fsm #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) u_md_wait_fsm (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_is_mul       (w_is_mul),
        .i_is_div       (w_is_div),
        .i_branch_taken (branch_taken),
        .i_md_ready     (md_ready),
        .o_md_ctrl_mult (md_ctrl_mult),
        .o_md_ctrl_div  (md_ctrl_div),
        .o_md_busy      (md_busy),
        .o_release      (w_release),
        .o_md_timeout   (md_timeout)
    );

    // The release cycle falls through to the hazard check so a RAW stall still applies.
    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        if (reset) begin
            {pc_we, fd_we, dx_we}           = 3'b000;
            {fd_flush, dx_bubble, xm_bubble} = 3'b111;
        end else if (md_busy && !w_release) begin
            {pc_we, fd_we, dx_we} = 3'b000;
            xm_bubble             = 1'b1;
        end else if (!md_busy && branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (w_start) begin
            {pc_we, fd_we, dx_we} = 3'b000;
            xm_bubble             = 1'b1;
        end else if (data_hazard) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_bubble = 1'b1;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic w_hz_evt;
    logic w_flush_evt;
    assign w_hz_evt    = !reset && !md_busy && !branch_taken && !w_start && data_hazard;
    assign w_flush_evt = !reset && !md_busy && branch_taken;
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_hazard_cyc <= '0;
            perf_md_cyc     <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (w_hz_evt && perf_hazard_cyc != '1) perf_hazard_cyc <= perf_hazard_cyc + 1'b1;
            if (md_busy && perf_md_cyc != '1) perf_md_cyc <= perf_md_cyc + 1'b1;
            if (w_flush_evt && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scenario tasks with a per-cycle expected-output scoreboard.
module tb_pipeline_stall_ctrl;
    localparam logic [31:0] INSN_MUL = 32'h00C22018;
    localparam logic [31:0] INSN_DIV = 32'h00C2201C;
    // {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble, mult, div, busy, timeout}
    localparam logic [9:0] E_RUN  = 10'b1110000000;
    localparam logic [9:0] E_RST  = 10'b0001110000;
    localparam logic [9:0] E_MULS = 10'b0000011000;
    localparam logic [9:0] E_DIVS = 10'b0000010100;
    localparam logic [9:0] E_WAIT = 10'b0000010010;
    localparam logic [9:0] E_REL  = 10'b1110000010;
    localparam logic [9:0] E_TO   = 10'b1110000011;
    localparam logic [9:0] E_HAZ  = 10'b0010100000;
    localparam logic [9:0] E_BR   = 10'b1111100000;
    localparam logic [9:0] E_RELH = 10'b0010100010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dx_insn = '0;
    logic        data_hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble;
    logic        md_ctrl_mult, md_ctrl_div, md_busy, md_timeout;
    logic [9:0]  w_out;
    logic [9:0]  exp_v;
    logic [9:0]  sb[$];
    int          n_vec = 0;
    int          n_err = 0;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_hazard_cyc, perf_md_cyc, perf_flush_cnt;
`endif

    always #5 clock = ~clock;

    pipeline_stall_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .dx_insn      (dx_insn),
        .data_hazard  (data_hazard),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .fd_flush     (fd_flush),
        .dx_bubble    (dx_bubble),
        .xm_bubble    (xm_bubble),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout)
`ifdef PIPE_STALL_PERF_EN
        ,
        .perf_hazard_cyc (perf_hazard_cyc),
        .perf_md_cyc     (perf_md_cyc),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    assign w_out = {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
                    md_ctrl_mult, md_ctrl_div, md_busy, md_timeout};

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            reset = (c < 3);
            dx_insn = '0; data_hazard = 0; branch_taken = 0; md_ready = 0;
            sb.push_back(c < 3 ? E_RST : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL reset[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_mul();
        for (int c = 0; c < 8; c++) begin
            reset = 0; data_hazard = 0; branch_taken = 0;
            dx_insn = (c < 6) ? INSN_MUL : 32'h0;
            md_ready = (c == 5);
            sb.push_back(c == 0 ? E_MULS : c < 5 ? E_WAIT : c == 5 ? E_REL : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL mul[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_div_timeout(input logic ready_on_last);
        for (int c = 0; c < 66; c++) begin
            reset = 0; data_hazard = 0; branch_taken = 0;
            dx_insn = (c < 65) ? INSN_DIV : 32'h0;
            md_ready = ready_on_last && (c == 64);
            sb.push_back(c == 0 ? E_DIVS : c < 64 ? E_WAIT : c == 64 ? (ready_on_last ? E_REL : E_TO) : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL div_to%0d[%0d] got %b want %b", ready_on_last, c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_hazard();
        for (int c = 0; c < 4; c++) begin
            reset = 0; branch_taken = 0; md_ready = 0; dx_insn = 32'h0;
            data_hazard = (c < 2);
            sb.push_back(c < 2 ? E_HAZ : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL hazard[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 6; c++) begin
            reset = 0; md_ready = 0;
            data_hazard = (c == 0 || c == 3);
            branch_taken = (c < 2 || c == 3);
            dx_insn = (c == 1 || c == 2 || c == 3) ? INSN_MUL : 32'h0;
            md_ready = (c == 4);
            // c1: branch squashes a mul in DX; c3: branch and hazard ignored while waiting
            sb.push_back(c < 2 ? E_BR : c == 2 ? E_MULS : c == 3 ? E_WAIT : c == 4 ? E_REL : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL branch[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            reset = 0; branch_taken = 0;
            dx_insn = (c < 2) ? INSN_MUL : (c < 5) ? INSN_DIV : 32'h0;
            md_ready = (c == 1 || c == 4 || c == 5);
            data_hazard = (c == 4);
            sb.push_back(c == 0 ? E_MULS : c == 1 ? E_REL : c == 2 ? E_DIVS : c == 3 ? E_WAIT : c == 4 ? E_RELH : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL b2b[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c < 71; c++) begin
            reset = (c == 3); data_hazard = 0; branch_taken = 0; md_ready = 0;
            dx_insn = (c < 4 || (c >= 5 && c < 70)) ? INSN_MUL : 32'h0;
            if (c == 4) dx_insn = 32'h0;
            sb.push_back(c == 0 || c == 5 ? E_MULS : c < 3 ? E_WAIT : c == 3 ? E_RST : c == 4 ? E_RUN :
                         c < 69 ? E_WAIT : c == 69 ? E_TO : E_RUN);
            @(negedge clock);
            exp_v = sb.pop_front(); n_vec++;
            if (w_out !== exp_v) begin n_err++; $display("FAIL rst_wait[%0d] got %b want %b", c, w_out, exp_v); end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div_timeout(1'b0);
        test_div_timeout(1'b1);
        test_hazard();
        test_branch();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
